// File: rtl/swu_pkg.sv
// Shared types and frame-geometry constants for the ECG sliding-window sequencer.
package swu_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 29;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned WIN_W_DEF  = 7;
    localparam int unsigned STRIDE_DEF = 2;

    function automatic int unsigned n_win_f(input int unsigned word_w,
                                            input int unsigned depth,
                                            input int unsigned win_w,
                                            input int unsigned stride);
        return (depth * word_w - win_w) / stride + 1;
    endfunction

    localparam int unsigned N_WIN = n_win_f(WORD_W_DEF, DEPTH_DEF, WIN_W_DEF, STRIDE_DEF);
    localparam int unsigned WC_W  = $clog2(N_WIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL0,
        ST_FILL1,
        ST_STREAM,
        ST_REFILL
    } swu_state_t;

endpackage

// File: rtl/swu_win_extract.sv
// Selects the WIN_W-bit window starting p bits into {cur,nxt}; MSB is the earliest bit.
module swu_win_extract
    import swu_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned WIN_W  = WIN_W_DEF,
    parameter int unsigned P_W    = $clog2(WORD_W_DEF)
) (
    input  logic [2*WORD_W-1:0] pair_i,
    input  logic [P_W-1:0]      p_i,
    output logic [WIN_W-1:0]    win_o
);

    always_comb begin
        win_o = pair_i[2*WORD_W-1-p_i -: WIN_W];
    end

endmodule

// File: rtl/swu_sched.sv
// Reads the ECG ROM word by word and streams fixed-stride windows over valid/ready,
// with start/busy/done frame control and a REFILL bubble per fetched word.
module swu_sched
    import swu_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned WIN_W  = WIN_W_DEF,
    parameter int unsigned STRIDE = STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WIN_W-1:0]  win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_last
);

    localparam int unsigned N_WIN_P = n_win_f(WORD_W, DEPTH, WIN_W, STRIDE);
    localparam int unsigned WC_L    = $clog2(N_WIN_P);
    localparam int unsigned P_W     = $clog2(WORD_W);
    localparam int unsigned NA_W    = ADDR_W + 1;

    swu_state_t        state_q, state_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic [WORD_W-1:0] nxt_q, nxt_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [NA_W-1:0]   na_q, na_d;
    logic [WC_L-1:0]   wc_q, wc_d;
    logic              fill_pend_q, fill_pend_d;
    logic              done_q, done_d;

    logic [31:0]       p_sum;
    logic              is_last;
    logic [WIN_W-1:0]  win_raw;

    assign is_last = (wc_q == WC_L'(N_WIN_P - 1));

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        p_d         = p_q;
        na_d        = na_q;
        wc_d        = wc_q;
        fill_pend_d = 1'b0;
        done_d      = 1'b0;
        rom_en      = 1'b0;
        rom_addr    = '0;
        p_sum       = 32'(p_q) + STRIDE;

        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) state_d = ST_FILL0;
            end
            ST_FILL0: begin
                rom_en  = 1'b1;
                state_d = ST_FILL1;
            end
            ST_FILL1: begin
                rom_en      = 1'b1;
                rom_addr    = ADDR_W'(1);
                cur_d       = rom_data;
                nxt_d       = '0;
                na_d        = NA_W'(2);
                p_d         = '0;
                wc_d        = '0;
                fill_pend_d = 1'b1;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                // Word 1 lands one cycle into STREAM (ROM latency); the p=0 window never reads nxt.
                if (fill_pend_q) nxt_d = rom_data;
                if (win_ready) begin
                    wc_d = wc_q + WC_L'(1);
                    if (is_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (p_sum >= WORD_W) begin
                        cur_d = fill_pend_q ? rom_data : nxt_q;
                        p_d   = P_W'(p_sum - WORD_W);
                        if (32'(na_q) < DEPTH) begin
                            rom_en   = 1'b1;
                            rom_addr = na_q[ADDR_W-1:0];
                            state_d  = ST_REFILL;
                        end else begin
                            nxt_d = '0;
                        end
                    end else begin
                        p_d = P_W'(p_sum);
                    end
                end
            end
            ST_REFILL: begin
                nxt_d   = rom_data;
                na_d    = na_q + NA_W'(1);
                state_d = ST_STREAM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            nxt_q       <= '0;
            p_q         <= '0;
            na_q        <= '0;
            wc_q        <= '0;
            fill_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            p_q         <= p_d;
            na_q        <= na_d;
            wc_q        <= wc_d;
            fill_pend_q <= fill_pend_d;
            done_q      <= done_d;
        end
    end

    swu_win_extract #(
        .WORD_W (WORD_W),
        .WIN_W  (WIN_W),
        .P_W    (P_W)
    ) u_extract (
        .pair_i ({cur_q, nxt_q}),
        .p_i    (p_q),
        .win_o  (win_raw)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign win_valid = (state_q == ST_STREAM);
    assign win_last  = win_valid && is_last;
    assign win_data  = win_valid ? win_raw : '0;

endmodule

// File: tb/tb_swu_sched.sv
// Directed bench for swu_sched: basic stream, full frames, backpressure, start handling, reset.
module tb_swu_sched;

    localparam int N_WIN = 461;
    localparam int DEPTH = 29;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rom_en;
    logic [4:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic [6:0] win_data;
    logic       win_valid, win_last;
    logic       win_ready = 1'b1;

    logic [31:0] mem [0:31];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    swu_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // Window idx taken bit by bit from the concatenated ROM stream.
    function automatic logic [6:0] exp_win(input int idx);
        logic [6:0] r;
        int pos;
        r = '0;
        for (int b = 0; b < 7; b++) begin
            pos = idx * 2 + b;
            r[6-b] = mem[pos/32][31-(pos%32)];
        end
        return r;
    endfunction

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1; start = 1'b0; win_ready = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic basic_stream();
        for (int k = 0; k < 32; k++) mem[k] = '0;
        mem[0] = 32'hA5A5A5A5;
        mem[1] = 32'hFFFFFFFF;
        win_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        check("b_fill0", {busy, rom_en, win_valid}, 3'b110);
        check("b_addr0", rom_addr, 0);
        @(negedge clk); #1;
        check("b_fill1", {rom_en, rom_addr}, {1'b1, 5'd1});
        @(negedge clk); #1;
        check("b_win0", {win_valid, win_data}, {1'b1, 7'h52});
        @(negedge clk); #1;
        check("b_win1", win_data, 7'h4B);
        repeat (14) @(negedge clk);
        #1;
        check("b_win15", win_data, 7'h3F);
        check("b_refill_rd", {rom_en, rom_addr}, {1'b1, 5'd2});
        @(negedge clk); #1;
        check("b_bubble", win_valid, 0);
        @(negedge clk); #1;
        check("b_win16", {win_valid, win_data}, {1'b1, 7'h7F});
        pulse_rst();
    endtask

    // mode: 0 ready=1, 1 random 30% ready, 2 start pokes, 3 stall on first p=30 window
    task automatic run_frame(input int mode, input int abort_at);
        int acc = 0, bub = 0, last_cnt = 0, last_bad = 0, first_v = -1;
        int done_cnt = 0, done_cyc = -1, last_acc_cyc = -1;
        int exp_addr = 0, addr_err = 0, hold = 0;
        bit prev_stall = 0, poked_s = 0, poked_r = 0, fin = 0;
        logic [6:0] prev_data = '0;
        @(negedge clk); start = 1'b1; win_ready = 1'b1;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            case (mode)
                1: win_ready = ($urandom_range(0, 9) < 3);
                3: begin
                    if (acc == 15 && hold < 5) begin win_ready = 1'b0; hold++; end
                    else win_ready = 1'b1;
                end
                default: win_ready = 1'b1;
            endcase
            #1;
            if (rom_en) begin
                if (32'(rom_addr) == exp_addr) exp_addr++;
                else addr_err++;
            end
            if (win_valid) begin
                if (first_v < 0) first_v = cyc;
                if (prev_stall) check("stall_hold", win_data, prev_data);
                if (mode == 3 && !win_ready) check("stall_no_rd", rom_en, 0);
                if (win_last != (acc == N_WIN - 1)) last_bad++;
                if (win_ready) begin
                    check("win", win_data, exp_win(acc));
                    if (win_last) last_cnt++;
                    acc++;
                    last_acc_cyc = cyc;
                end
                prev_stall = !win_ready;
                prev_data  = win_data;
                if (mode == 2 && acc == 50 && !poked_s) begin start = 1'b1; poked_s = 1; end
            end else if (busy && first_v >= 0) begin
                bub++;
                if (mode == 2 && !poked_r) begin start = 1'b1; poked_r = 1; end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_last", cyc, last_acc_cyc + 1);
                check("done_busy", busy, 0);
                fin = 1;
                if (mode == 2) start = 1'b1;
            end
            if (abort_at >= 0 && acc == abort_at) begin rst = 1'b1; fin = 1; end
        end
        if (abort_at >= 0) begin
            @(negedge clk); #1;
            check("rst_mid_out", {busy, done, rom_en, win_valid, win_last, rom_addr, win_data}, 0);
            check("rst_mid_acc", acc, abort_at);
            rst = 1'b0;
            return;
        end
        check("n_accept", acc, N_WIN);
        check("n_bubble", bub, 27);
        check("last_bad", last_bad, 0);
        check("last_cnt", last_cnt, 1);
        check("done_cnt", done_cnt, 1);
        check("rom_seq", exp_addr, DEPTH);
        check("rom_addr_err", addr_err, 0);
        check("first_valid", first_v, 2);
        if (mode == 0) check("frame_cycles", done_cyc - first_v, 488);
        if (mode == 2) begin
            check("pokes", {poked_s, poked_r}, 2'b11);
            @(negedge clk); #1;
            check("start_on_done_ign", {busy, rom_en}, 0);
            @(negedge clk); start = 1'b0; #1;
            check("restart_fill0", {busy, rom_en, rom_addr}, {1'b1, 1'b1, 5'd0});
            @(negedge clk);
            @(negedge clk); #1;
            check("restart_valid", {win_valid, win_data}, {1'b1, exp_win(0)});
            pulse_rst();
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out", {busy, done, rom_en, win_valid, win_last, rom_addr, win_data}, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_out", {busy, done, rom_en, win_valid, win_last, rom_addr, win_data}, 0);

        basic_stream();

        for (int k = 0; k < 32; k++) mem[k] = k * 32'h01010101;
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(3, -1);
        run_frame(2, -1);
        run_frame(0, 200);
        run_frame(0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
